// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter and the memory model:
// bus widths, enable levels and the arbiter FSM/owner encodings.
package mem_arbiter_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned DataAddrBus = 32;
  localparam int unsigned DataBus     = 32;

  localparam logic [31:0] ZeroWord     = '0;
  localparam logic        ChipEnable   = 1'b1;
  localparam logic        ChipDisable  = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // Legal multi-byte enable patterns for the data port.
  localparam logic [3:0] SelWord   = 4'b1111;
  localparam logic [3:0] SelLoHalf = 4'b0011;
  localparam logic [3:0] SelHiHalf = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port of the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DataAddrBus,
  parameter int unsigned DATA_W = DataBus
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [SEL_W-1:0]  dm_sel;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic              dm_err;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_ce;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_req;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    output if_ack, if_err, if_rdata,
    input  dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
    output dm_ack, dm_err, dm_rdata,
    output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_req
  );

  // Requester / memory side.
  modport master (
    output if_req, if_addr,
    input  if_ack, if_err, if_rdata,
    output dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
    input  dm_ack, dm_err, dm_rdata,
    input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_req
  );

endinterface

// File: rtl/mem_align_chk.sv
// Alignment check for one memory access. Fetches must be word aligned;
// data accesses may be a single byte, an aligned halfword (0011/1100) or an
// aligned word (1111). Every other enable pattern is rejected.
module mem_align_chk
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [3:0] sel,
  input  logic       is_fetch,
  output logic       misaligned
);

  // Classify the access from its low address bits and byte enables.
  always_comb begin
    misaligned = 1'b1;
    if (is_fetch) begin
      misaligned = (addr != 2'b00);
    end else begin
      case (sel)
        SelWord:                           misaligned = (addr != 2'b00);
        SelLoHalf, SelHiHalf:              misaligned = addr[0];
        4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
        default:                           misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between fetch and load/store.
// One access at a time: grant -> CMD (memory command) -> RESP (ack + data),
// or grant -> ERR (error ack, no memory command) for misaligned requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = DataBus
)(
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned SEL_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [SEL_W-1:0]  cmd_sel_q, cmd_sel_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic              gnt_valid;
  logic              gnt_dm;
  logic [1:0]        chk_addr;
  logic [SEL_W-1:0]  chk_sel;
  logic              misaligned;

  logic              in_cmd;
  logic              in_ack;
  logic              rd_ok;
  logic              if_ack;
  logic              dm_ack;

  // Grant candidate: IDLE looks at both ports with data first; RESP/ERR only
  // at the port not just served, which forces alternation under contention.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_dm    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_dm    = bus.dm_req;
        gnt_valid = bus.dm_req | bus.if_req;
      end
      RESP, ERR: begin
        gnt_dm    = (owner_q == OWN_IF);
        gnt_valid = (owner_q == OWN_IF) ? bus.dm_req : bus.if_req;
      end
      default: ;
    endcase
  end

  assign chk_addr = gnt_dm ? bus.dm_addr[1:0] : bus.if_addr[1:0];
  assign chk_sel  = gnt_dm ? bus.dm_sel : '1;

  mem_align_chk u_align_chk (
    .addr       (chk_addr),
    .sel        (chk_sel),
    .is_fetch   (~gnt_dm),
    .misaligned (misaligned)
  );

  // Next state, owner and latched command.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (state_q == CMD) begin
      state_d = RESP;
    end else if (gnt_valid) begin
      owner_d = gnt_dm ? OWN_DM : OWN_IF;
      state_d = misaligned ? ERR : CMD;
      if (!misaligned) begin
        cmd_we_d    = gnt_dm & bus.dm_we;
        cmd_sel_d   = gnt_dm ? bus.dm_sel : '1;
        cmd_addr_d  = gnt_dm ? bus.dm_addr : bus.if_addr;
        cmd_wdata_d = gnt_dm ? bus.dm_wdata : ZeroWord;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State and command registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cmd_we_q    <= 1'b0;
      cmd_sel_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign in_cmd = (state_q == CMD);
  assign in_ack = (state_q == RESP) | (state_q == ERR);
  assign rd_ok  = (state_q == RESP) & ~cmd_we_q;
  assign if_ack = in_ack & (owner_q == OWN_IF);
  assign dm_ack = in_ack & (owner_q == OWN_DM);

  assign bus.if_ack   = if_ack;
  assign bus.if_err   = if_ack & (state_q == ERR);
  assign bus.if_rdata = (if_ack & rd_ok) ? bus.mem_rdata : '0;
  assign bus.dm_ack   = dm_ack;
  assign bus.dm_err   = dm_ack & (state_q == ERR);
  assign bus.dm_rdata = (dm_ack & rd_ok) ? bus.mem_rdata : '0;

  // Enables are gated by rst so a store whose command cycle meets reset never commits.
  assign bus.mem_ce    = (in_cmd & ~rst) ? ChipEnable : ChipDisable;
  assign bus.mem_we    = (in_cmd & cmd_we_q & ~rst) ? WriteEnable : WriteDisable;
  assign bus.mem_sel   = in_cmd ? cmd_sel_q : '0;
  assign bus.mem_addr  = in_cmd ? cmd_addr_q : '0;
  assign bus.mem_wdata = in_cmd ? cmd_wdata_q : '0;

  assign bus.stall_req = (bus.if_req & ~if_ack) | (bus.dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, each
// cycle compared against a transaction-schedule model and a reference memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NONE = 0;
  localparam int PIF  = 1;
  localparam int PDM  = 2;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] k;
    k = i[7:0];
    if (i == 64) return 32'h0000_0013;
    return {k, 8'h5A, ~k, 8'hC3};
  endfunction

  // Memory attached to the arbiter: synchronous read, byte-enable write.
  logic [31:0] env_mem [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
    end else if (bus.mem_ce && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_sel[b]) env_mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    if (bus.mem_ce && !bus.mem_we) bus.mem_rdata <= env_mem[bus.mem_addr[9:2]];
    else                           bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  int n_chk;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: which port is being served, and when its command and
  // ack are due, plus the expected memory contents.
  logic [31:0] ref_mem [0:255];
  int          cur;
  int          cyc;
  int          t_cmd;
  int          t_ack;
  logic        c_we;
  logic        c_err;
  logic [3:0]  c_sel;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        if_acked;
  logic        dm_acked;
  logic        obs_if_ack;
  logic        obs_dm_ack;
  logic [31:0] last_if_rdata;
  logic [31:0] last_dm_rdata;
  int          ce_seen;

  // Legal data access: one byte anywhere, a halfword on an even address,
  // or a full word on a word address.
  function automatic logic dm_legal(input logic [3:0] sel, input logic [31:0] addr);
    int size;
    size = $countones(sel);
    if (size == 1) return 1'b1;
    if (size == 2 && (sel == 4'b0011 || sel == 4'b1100)) return (addr % 2) == 0;
    if (size == 4) return (addr % 4) == 0;
    return 1'b0;
  endfunction

  task automatic sched(input int p);
    cur = p;
    if (p == PDM) begin
      c_we    = bus.dm_we;
      c_sel   = bus.dm_sel;
      c_addr  = bus.dm_addr;
      c_wdata = bus.dm_wdata;
      c_err   = !dm_legal(bus.dm_sel, bus.dm_addr);
    end else begin
      c_we    = 1'b0;
      c_sel   = 4'hF;
      c_addr  = bus.if_addr;
      c_wdata = 32'h0;
      c_err   = (bus.if_addr % 4) != 0;
    end
    if (c_err) begin
      t_cmd = -1;
      t_ack = cyc + 1;
    end else begin
      t_cmd = cyc + 1;
      t_ack = cyc + 2;
    end
  endtask

  task automatic check_outputs();
    logic        in_cmd;
    logic        ack;
    logic [31:0] exp_rd;
    in_cmd = (cur != NONE) && (t_cmd == cyc);
    ack    = (cur != NONE) && (t_ack == cyc);
    exp_rd = (ack && !c_err && !c_we) ? ref_mem[c_addr[9:2]] : 32'h0;
    check_eq("mem_ce",    32'(bus.mem_ce),    32'(in_cmd && !rst));
    check_eq("mem_we",    32'(bus.mem_we),    32'(in_cmd && c_we && !rst));
    check_eq("mem_sel",   32'(bus.mem_sel),   in_cmd ? 32'(c_sel) : 32'h0);
    check_eq("mem_addr",  bus.mem_addr,       in_cmd ? c_addr : 32'h0);
    check_eq("mem_wdata", bus.mem_wdata,      in_cmd ? c_wdata : 32'h0);
    check_eq("if_ack",    32'(bus.if_ack),    32'(ack && cur == PIF));
    check_eq("if_err",    32'(bus.if_err),    32'(ack && cur == PIF && c_err));
    check_eq("if_rdata",  bus.if_rdata,       (cur == PIF) ? exp_rd : 32'h0);
    check_eq("dm_ack",    32'(bus.dm_ack),    32'(ack && cur == PDM));
    check_eq("dm_err",    32'(bus.dm_err),    32'(ack && cur == PDM && c_err));
    check_eq("dm_rdata",  bus.dm_rdata,       (cur == PDM) ? exp_rd : 32'h0);
    check_eq("stall_req", 32'(bus.stall_req),
             32'((bus.if_req && !(ack && cur == PIF)) || (bus.dm_req && !(ack && cur == PDM))));
    obs_if_ack = bus.if_ack;
    obs_dm_ack = bus.dm_ack;
    if (bus.if_ack) last_if_rdata = bus.if_rdata;
    if (bus.dm_ack) last_dm_rdata = bus.dm_rdata;
    if (bus.mem_ce) ce_seen++;
  endtask

  task automatic model_step();
    if_acked = (cur == PIF) && (t_ack == cyc);
    dm_acked = (cur == PDM) && (t_ack == cyc);
    if (cur != NONE && t_cmd == cyc && !rst && c_we)
      for (int b = 0; b < 4; b++)
        if (c_sel[b]) ref_mem[c_addr[9:2]][8*b +: 8] = c_wdata[8*b +: 8];
    if (rst) begin
      cur = NONE;
    end else if (cur != NONE && t_ack == cyc) begin
      if (cur == PDM && bus.if_req)      sched(PIF);
      else if (cur == PIF && bus.dm_req) sched(PDM);
      else                               cur = NONE;
    end else if (cur == NONE) begin
      if (bus.dm_req)      sched(PDM);
      else if (bus.if_req) sched(PIF);
    end
    cyc++;
  endtask

  // One clock cycle: check mid-cycle, advance the model, move inputs just after the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Requesters drop their request after the ack; bounded by maxc cycles.
  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while ((bus.if_req || bus.dm_req) && n < maxc) begin
      tick();
      n++;
      if (if_acked) bus.if_req = 1'b0;
      if (dm_acked) bus.dm_req = 1'b0;
    end
    tick();
  endtask

  logic [3:0] sel_tab [11];
  logic [8:0] seq_if;
  logic [8:0] seq_dm;
  int         a;

  initial begin
    n_chk = 0; n_err = 0;
    cur = NONE; cyc = 0; t_cmd = -1; t_ack = -1;
    c_we = 1'b0; c_err = 1'b0; c_sel = '0; c_addr = '0; c_wdata = '0;
    if_acked = 1'b0; dm_acked = 1'b0; ce_seen = 0;
    last_if_rdata = '0; last_dm_rdata = '0;
    sel_tab = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h5, 4'h6};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    rst = 1'b1; mem_init = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_sel = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    tick();                                   // reset state
    rst = 1'b0;
    tick();

    // Single fetch of word 0x100.
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    run_until_idle(10);
    check_eq("fetch_word", last_if_rdata, 32'h0000_0013);

    // Byte store to 0x104, then load it back.
    bus.dm_we = 1'b1; bus.dm_sel = 4'b0001; bus.dm_addr = 32'h104; bus.dm_wdata = 32'hAB;
    bus.dm_req = 1'b1;
    run_until_idle(10);
    bus.dm_we = 1'b0; bus.dm_sel = 4'hF;
    bus.dm_req = 1'b1;
    run_until_idle(10);
    check_eq("load_byte", 32'(last_dm_rdata[7:0]), 32'hAB);

    // Contention: both ports keep requesting; acks must alternate DM, IF, DM, IF.
    bus.if_addr = 32'h200; bus.if_req = 1'b1; bus.dm_req = 1'b1;
    seq_if = '0; seq_dm = '0;
    for (int c = 0; c < 9; c++) begin
      tick();
      seq_if[c] = obs_if_ack;
      seq_dm[c] = obs_dm_ack;
    end
    check_eq("cont_dm_acks", 32'(seq_dm), 32'h044);
    check_eq("cont_if_acks", 32'(seq_if), 32'h110);
    run_until_idle(20);

    // Misaligned word load and fetch: error acks, memory never enabled.
    ce_seen = 0;
    bus.dm_we = 1'b0; bus.dm_sel = 4'hF; bus.dm_addr = 32'h102; bus.dm_req = 1'b1;
    run_until_idle(10);
    bus.if_addr = 32'h101; bus.if_req = 1'b1;
    run_until_idle(10);
    check_eq("misalign_no_ce", 32'(ce_seen), 32'h0);

    // Reset in the command cycle of a store: the store must not land.
    bus.dm_we = 1'b1; bus.dm_sel = 4'hF; bus.dm_addr = 32'h108; bus.dm_wdata = 32'h1234_5678;
    bus.dm_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.dm_req = 1'b0;
    tick();
    tick();
    bus.dm_we = 1'b0; bus.dm_req = 1'b1;
    run_until_idle(10);
    check_eq("rst_store_dropped", last_dm_rdata, init_word(66));

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.if_req || if_acked) begin
        if ($urandom_range(0, 3) != 0) begin
          a = int'($urandom_range(0, 255)) * 4;
          if ($urandom_range(0, 5) == 0) a = a + int'($urandom_range(1, 3));
          bus.if_addr = 32'(a);
          bus.if_req  = 1'b1;
        end else begin
          bus.if_req = 1'b0;
        end
      end
      if (!bus.dm_req || dm_acked) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.dm_we    = 1'($urandom_range(0, 1));
          bus.dm_sel   = sel_tab[$urandom_range(0, 10)];
          bus.dm_addr  = 32'($urandom_range(0, 1023));
          bus.dm_wdata = $urandom;
          bus.dm_req   = 1'b1;
        end else begin
          bus.dm_req = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    run_until_idle(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
